keypad_scan: RTL
================

# keypad_scan

Memory-mapped 4×4 matrix keypad input peripheral: the input-side counterpart to the 7-segment display device on the same CPU data bus. The block drives row-select lines in rotation and samples the column returns. It debounces one key at a time and latches the key code into a register for the CPU to read and acknowledge. It sits on the peripheral bus next to the display device, using the same word-register bus signals.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each row stays driven; one sample per period.
- DEB_FRAMES, 4: consecutive matching samples required to accept a press or a release (≥2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- D  in  32  write data.
- A  in  1  register select: 0 = KEY, 1 = CTRL.
- be  in  4  byte enables; only byte 0 is decoded (be[0]).
- we  in  1  write strobe.
- Dout  out  32  read data, combinational from A.
- row  out  4  row drive, active-low; one bit low while scanning.
- col  in  4  column return, active-low, externally pulled up, asynchronous.
- irq  out  1  high while a key code is pending.

## Operation
- col passes through a 2-flop synchronizer before use (reset value 4'hF).
- timer counts 0..SCAN_DIV-1. The sample point is timer==SCAN_DIV-1, and timer wraps after it.
- KEY (A=0) read: [31] valid, [30] overflow, [8] pressed_now (FSM in HELD), [3:0] code = row_idx*4 + col_idx. All other bits are 0. Writes to KEY are ignored.
- CTRL (A=1) read: [0] enable, all other bits 0.
- CTRL write (we & be[0]):
  - D[0] sets enable.
  - D[1]=1 is an ack: pops one code and clears overflow. D[1] is self-clearing and always reads 0.
- FSM:
  - IDLE: row index r drives row = ~(1<<r). At each sample point:
    - Any synced col bit low: candidate col = lowest low bit, deb=1, go to DEBOUNCE. r is held.
    - No col bit low: r advances by 1, mod 4.
  - DEBOUNCE: at each sample point:
    - Candidate col still low: deb+1. On reaching DEB_FRAMES, push code {r,col} and go to HELD.
    - Candidate col high: go to IDLE with r+1.
  - HELD: rel counter runs at each sample point.
    - Candidate col high: rel+1. On reaching DEB_FRAMES, go to IDLE with r+1.
    - Candidate col low: rel=0.
- Other keys pressed during DEBOUNCE or HELD are ignored.
- enable=0: FSM forced to IDLE, r=0, timer=0, row=4'hF. Pending codes are retained and can still be acked.
- Push into a full store: the code is discarded and overflow is set.
- Push and ack in the same cycle: the ack pops the old code and the push stores the new one. Overflow is not set.
- Ack while empty: no effect on codes; overflow is still cleared.
- Reset mid-scan: every state returns to its reset value on the next edge, with no partial push.

## Timing
- Reset values: row=4'hF, irq=0, enable=0, valid=0, overflow=0, code=0, FSM=IDLE, r=0, timer=0, deb=0, rel=0.
- Column-to-sample latency is 2 cycles (synchronizer). The row settles for SCAN_DIV-3 cycles before sampling.
- Press acceptance: push occurs (DEB_FRAMES-1)×SCAN_DIV cycles after the first detecting sample. valid and irq rise 1 cycle after the push-edge sample.
- An ack write at edge N makes valid/irq reflect the new occupancy after edge N.
- Dout has no read side effects.

## Configuration
- KEYPAD_FIFO_EN defined: code store is a 4-entry FIFO.
  - valid = not empty; code = head entry.
  - Overflow is set on a push while 4 entries are occupied.
- Not defined: single-entry register.
  - Overflow is set on a push while valid=1. The new code is dropped and the old code is kept.

## Structure
- Shared package keypad_pkg: FSM state enum (IDLE, DEBOUNCE, HELD), register addresses KEY=0 and CTRL=1, KEY bit positions (VALID=31, OVF=30, PRESSED=8), CTRL bit positions (EN=0, ACK=1).
- Sub-module keypad_fifo: 4×4-bit FIFO with push/pop/full/empty and simultaneous push+pop support. Instantiated only under KEYPAD_FIFO_EN.

## Test plan
Bench parameters: SCAN_DIV=8, DEB_FRAMES=3.
- Reset: rst_n=0 for 2 cycles → row=4'hF, irq=0, KEY reads 0, CTRL reads 0.
- Enable, then hold col=4'b1101 while row=4'b1011 (r=2) → row stops rotating; after 2 further sample points KEY=32'h8000_0109 and irq=1.
- Release the key for 3 sample points → pressed_now=0 and rotation resumes at r=3. Write CTRL=32'h3 → KEY=32'h0000_0009 and irq=0 on the next cycle.
- Glitch: col low for only 1 sample on r=0 → no push; rotation resumes at r=1.
- Two presses without ack:
  - Without KEYPAD_FIFO_EN: KEY keeps the first code with bit 30 set.
  - With KEYPAD_FIFO_EN: 5 presses → 4 codes read back in order, then overflow=1.
- Ack in the same cycle as a push (single-entry build) → valid stays 1, code becomes the new key, overflow stays 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants for the keypad scanner and its code store.
// Holds FSM state encodings, register addresses, register bit positions and column priority.
package keypad_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t DEBOUNCE = 2'd1;
  localparam state_t HELD     = 2'd2;

  localparam logic ADDR_KEY  = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int KEY_VALID   = 31;
  localparam int KEY_OVF     = 30;
  localparam int KEY_PRESSED = 8;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_ACK    = 1;

  // Lowest-numbered active-low column wins when several are down at once.
  function automatic logic [1:0] lowest_low(input logic [3:0] c);
    if (!c[0]) return 2'd0;
    if (!c[1]) return 2'd1;
    if (!c[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_fifo.sv
// keypad_fifo: 4-entry code queue with push/pop, full/empty flags.
// A pop frees a slot in the same cycle, so push+pop on a full queue is accepted.
module keypad_fifo #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr_reg;
  logic [1:0]   rd_ptr_reg;
  logic [2:0]   count_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_reg == 3'd0);
  assign full    = (count_reg == 3'd4);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];

  for (genvar gi = 0; gi < 4; gi++) begin : g_entry
    logic [W-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_reg <= '0;
      end else if (do_push && (wr_ptr_reg == 2'(gi))) begin
        data_reg <= din;
      end
    end
    assign mem[gi] = data_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      count_reg  <= 3'd0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      count_reg <= count_reg + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a CPU-readable KEY/CTRL register pair.
// Define KEYPAD_FIFO_EN to queue up to four codes; otherwise a single code register is used.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] D,
  input  logic        A,
  input  logic [3:0]  be,
  input  logic        we,
  output logic [31:0] Dout,
  output logic [3:0]  row,
  input  logic [3:0]  col,
  output logic        irq
);

  localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] FRAMES_LAST = CW'(DEB_FRAMES - 1);

  logic [3:0]    col_meta_reg;
  logic [3:0]    col_sync_reg;
  logic [TW-1:0] timer_reg;
  logic          enable_reg;
  logic          ovf_reg;
  state_t        state_reg;
  logic [1:0]    r_reg;
  logic [1:0]    cand_reg;
  logic [CW-1:0] deb_reg;
  logic [CW-1:0] rel_reg;

  logic       sample;
  logic       ctrl_wr;
  logic       ack;
  logic       push;
  logic [3:0] push_code;
  logic       valid;
  logic       full;
  logic [3:0] code;
  logic       unused_bits;

  assign unused_bits = ^{D[31:2], be[3:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta_reg <= 4'hF;
      col_sync_reg <= 4'hF;
    end else begin
      col_meta_reg <= col;
      col_sync_reg <= col_meta_reg;
    end
  end

  assign ctrl_wr = we && be[0] && (A == ADDR_CTRL);
  assign ack     = ctrl_wr && D[CTRL_ACK];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_reg <= 1'b0;
    end else if (ctrl_wr) begin
      enable_reg <= D[CTRL_EN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable_reg) begin
      timer_reg <= '0;
    end else if (timer_reg == TIMER_LAST) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + TW'(1);
    end
  end

  assign sample = enable_reg && (timer_reg == TIMER_LAST);

  // The row stays driven through DEBOUNCE/HELD so the candidate column keeps reading the same key.
  assign row = enable_reg ? ~(4'b0001 << r_reg) : 4'hF;

  assign push_code = {r_reg, cand_reg};
  assign push = sample && (state_reg == DEBOUNCE) && !col_sync_reg[cand_reg]
                && (deb_reg == FRAMES_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable_reg) begin
      state_reg <= IDLE;
      r_reg     <= 2'd0;
      cand_reg  <= 2'd0;
      deb_reg   <= '0;
      rel_reg   <= '0;
    end else if (sample) begin
      case (state_reg)
        IDLE: begin
          if (col_sync_reg != 4'hF) begin
            cand_reg  <= lowest_low(col_sync_reg);
            deb_reg   <= CW'(1);
            state_reg <= DEBOUNCE;
          end else begin
            r_reg <= r_reg + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_sync_reg[cand_reg]) begin
            deb_reg <= deb_reg + CW'(1);
            if (deb_reg == FRAMES_LAST) begin
              state_reg <= HELD;
              rel_reg   <= '0;
            end
          end else begin
            state_reg <= IDLE;
            r_reg     <= r_reg + 2'd1;
            deb_reg   <= '0;
          end
        end
        HELD: begin
          if (col_sync_reg[cand_reg]) begin
            if (rel_reg == FRAMES_LAST) begin
              state_reg <= IDLE;
              r_reg     <= r_reg + 2'd1;
              rel_reg   <= '0;
              deb_reg   <= '0;
            end else begin
              rel_reg <= rel_reg + CW'(1);
            end
          end else begin
            rel_reg <= '0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_FIFO_EN
  logic empty;

  keypad_fifo #(.W(4)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (ack),
    .din   (push_code),
    .dout  (code),
    .full  (full),
    .empty (empty)
  );

  assign valid = !empty;
`else
  logic       valid_reg;
  logic [3:0] code_reg;

  // An ack in the same cycle as a push frees the slot, so the new code replaces the old one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      code_reg  <= 4'd0;
    end else begin
      if (ack) valid_reg <= 1'b0;
      if (push && (!valid_reg || ack)) begin
        valid_reg <= 1'b1;
        code_reg  <= push_code;
      end
    end
  end

  assign full  = valid_reg;
  assign valid = valid_reg;
  assign code  = code_reg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (ack) begin
      ovf_reg <= 1'b0;
    end else if (push && full) begin
      ovf_reg <= 1'b1;
    end
  end

  assign irq = valid;

  always_comb begin
    Dout = '0;
    if (A == ADDR_KEY) begin
      Dout[KEY_VALID]   = valid;
      Dout[KEY_OVF]     = ovf_reg;
      Dout[KEY_PRESSED] = (state_reg == HELD);
      Dout[3:0]         = code;
    end else begin
      Dout[CTRL_EN] = enable_reg;
    end
  end

endmodule
